fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one 8-bit-wide FIFO write port among N producers. It grants the port to one requester at a time for a bounded burst, then drives the FIFO's `wr`/`din` and honours the FIFO's `full` flag. It sits between producer blocks and the FIFO, and is the only block allowed to drive the FIFO write side.

---
 rtl/fifo_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Purpose: round-robin arbiter that gives N producers turns at one FIFO write port, one bounded burst per grant.
// Latency: grant registered one edge after req is seen in IDLE; words are accepted combinationally (ack/fifo_wr) in the same cycle.
// Backpressure: fifo_full stalls the owner in place (grant and count hold, no timeout); optional FIFO_ARB_PRIO_EN gives requester 0 priority.
module fifo_write_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] din_bus,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic            fifo_wr,
    output logic [DW-1:0]   fifo_din,
    input  logic            fifo_full,
    output logic            busy
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int IW = $clog2(N);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            owner_req;
    logic [DW-1:0]   owner_dat;
    logic            accept;
    logic            burst_done;

    // Pick the next winner: first set req bit searching circularly from last+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!win_found && req[i] && (((int'(last_q) + k) % N) == i)) begin
                    win_found = 1'b1;
                    win_idx   = IW'(i);
                end
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        // Requester 0 overrides the rotation whenever it asks.
        if (req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`else
`endif
    end

    // Select the owner's request bit and data slice.
    always_comb begin
        owner_req = 1'b0;
        owner_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                owner_req = req[i];
                owner_dat = din_bus[i*DW +: DW];
            end
        end
    end

    // Next-state logic and combinational write-side outputs.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        burst_done = 1'b0;
        ack        = '0;
        fifo_wr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d   = N'(1) << win_idx;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end else begin
                    gnt_d   = '0;
                end
            end
            S_BURST: begin
                accept  = owner_req && !fifo_full;
                fifo_wr = accept;
                if (accept) begin
                    ack   = N'(1) << owner_q;
                    cnt_d = cnt_q + CW'(1);
                end
                // Leave after the last counted word, or as soon as the owner withdraws.
                burst_done = (accept && (cnt_q == CW'(BURST_LEN - 1))) || !owner_req;
                if (burst_done) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; last starts at N-1 so the first grant goes to requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output drive; fifo_din follows the owner even when no write is issued.
    always_comb begin
        gnt      = gnt_q;
        busy     = (state_q == S_BURST);
        fifo_din = owner_dat;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din_bus;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic            fifo_full;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit       rst_b;
        bit [3:0] req;
        bit       full;
        bit [3:0] gnt;
        bit [3:0] ack;
        bit       wr;
        bit       busy;
        bit [7:0] din;
    } vec_t;

    vec_t tbl[$];

    fifo_write_arbiter #(.N(N), .DW(DW), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din_bus   (din_bus),
        .gnt       (gnt),
        .ack       (ack),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit rb, input bit [3:0] r, input bit f, input bit [3:0] g,
                       input bit [3:0] a, input bit w, input bit b, input bit [7:0] d);
        vec_t v;
        v.rst_b = rb; v.req = r; v.full = f; v.gnt = g;
        v.ack = a; v.wr = w; v.busy = b; v.din = d;
        tbl.push_back(v);
    endtask

    // Idle row helper: registered grant clear, nothing written.
    task automatic add_idle(input bit rb, input bit [3:0] r);
        add(rb, r, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
    endtask

    // Hold reset low for a cycle, check the reset outputs, release on a falling edge.
    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_gnt",  int'(gnt), 0);
        chk("rst_ack",  int'(ack), 0);
        chk("rst_wr",   int'(fifo_wr), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic bit [7:0] slice_val(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    initial begin
        int own;
        bit [3:0] oh;

        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        din_bus   = {8'h44, 8'h33, 8'h22, 8'h11};

        // A: lone requester 0, back-to-back bursts separated by one idle cycle.
        add_idle(1'b1, 4'b0001);
        for (int w = 0; w < BL; w++) add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        add_idle(1'b0, 4'b0001);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);

        // B: all four requesting; rotation 0,1,2,3,0 (always 0 with priority build).
        add_idle(1'b1, 4'b1111);
        for (int g = 0; g < 5; g++) begin
`ifdef FIFO_ARB_PRIO_EN
            own = 0;
`else
            own = g % 4;
`endif
            oh = 4'(1 << own);
            for (int w = 0; w < BL; w++) add(1'b0, 4'b1111, 1'b0, oh, oh, 1'b1, 1'b1, slice_val(own));
            if (g < 4) add_idle(1'b0, 4'b1111);
        end

        // C: full for three cycles after the second word; grant holds, two more words, then idle.
        add_idle(1'b1, 4'b0001);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        for (int s = 0; s < 3; s++) add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'h00);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        add_idle(1'b0, 4'b0001);

        // D: requester 2 withdraws after two words; one idle cycle then requester 3.
        add_idle(1'b1, 4'b1100);
        add(1'b0, 4'b1100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'h33);
        add(1'b0, 4'b1100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'h33);
        add(1'b0, 4'b1000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h00);
        add_idle(1'b0, 4'b1000);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 8'h44);

        // E: owner withdraws right after its final counted word; single exit, single idle.
        add_idle(1'b1, 4'b0001);
        for (int w = 0; w < BL - 1; w++) add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11);
        add_idle(1'b0, 4'b0010);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'h22);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (tbl[i].rst_b) do_reset();
            req       = tbl[i].req;
            fifo_full = tbl[i].full;
            #1;
            chk($sformatf("v%0d_gnt", i),  int'(gnt),     int'(tbl[i].gnt));
            chk($sformatf("v%0d_ack", i),  int'(ack),     int'(tbl[i].ack));
            chk($sformatf("v%0d_wr", i),   int'(fifo_wr), int'(tbl[i].wr));
            chk($sformatf("v%0d_busy", i), int'(busy),    int'(tbl[i].busy));
            if (tbl[i].wr) chk($sformatf("v%0d_din", i), int'(fifo_din), int'(tbl[i].din));
        end

        // Asynchronous reset in the middle of a burst, then first grant goes to requester 1.
        @(negedge clk);
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        #1;
        chk("mid_wr0", int'(fifo_wr), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_gnt",  int'(gnt), 0);
        chk("mid_wr",   int'(fifo_wr), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_ack",  int'(ack), 0);
        req = 4'b1010;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_idle_gnt", int'(gnt), 0);
        @(posedge clk);
        #1;
        chk("post_gnt", int'(gnt), 4'b0010);
        chk("post_ack", int'(ack), 4'b0010);
        chk("post_din", int'(fifo_din), 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
